// File: rtl/io_hex_reader.sv
// Hex byte reader for the dev_io character interface: pops ASCII characters,
// assembles two-digit hex bytes committed on CR/LF, and optionally echoes input.
module io_hex_reader #(
  parameter bit ECHO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       getc_en,
  input  logic [7:0] getc_char,
  output logic       getc_pop,
  input  logic       putc_en,
  output logic       putc_push,
  output logic [7:0] putc_char,
  output logic [7:0] val,
  output logic       val_valid,
  output logic       err
);

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_ECHO,
    S_ECHO_LF
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] ch_q, ch_d;
  logic [7:0] val_q, val_d;
  logic       val_valid_q, val_valid_d;
  logic       err_q, err_d;
  logic [7:0] last_tx_q, last_tx_d;
  logic       pop_c;
  logic [4:0] hex_c;

  // Returns {is_hex, nibble}; letters share the low nibble pattern 1..6 in both cases.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, c[3:0]};
    end
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, c[3:0] + 4'd9};
    end
    return 5'd0;
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    val_d       = val_q;
    val_valid_d = 1'b0;
    err_d       = 1'b0;
    last_tx_d   = last_tx_q;
    pop_c       = 1'b0;
    putc_push   = 1'b0;
    putc_char   = last_tx_q;
    hex_c       = hex_decode(ch_q);

    unique case (state_q)
      S_IDLE: begin
        if (getc_en) begin
          pop_c   = 1'b1;
          ch_d    = getc_char;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (hex_c[4]) begin
          if (cnt_q >= 2'd2) begin
            err_d = 1'b1;
            cnt_d = 2'd0;
          end else begin
            acc_d = {acc_q[3:0], hex_c[3:0]};
            cnt_d = cnt_q + 2'd1;
          end
        end else if (ch_q == CHAR_CR || ch_q == CHAR_LF) begin
          // An empty line (cnt 0) is silent, so CRLF commits only once.
          if (cnt_q == 2'd2) begin
            val_d       = acc_q;
            val_valid_d = 1'b1;
          end else if (cnt_q == 2'd1) begin
            err_d = 1'b1;
          end
          cnt_d = 2'd0;
        end else begin
          err_d = 1'b1;
          cnt_d = 2'd0;
        end
        state_d = ECHO ? S_ECHO : S_IDLE;
      end

      S_ECHO: begin
        if (putc_en) begin
          putc_push = 1'b1;
          putc_char = ch_q;
          last_tx_d = ch_q;
          state_d   = (ch_q == CHAR_CR) ? S_ECHO_LF : S_IDLE;
        end
      end

      S_ECHO_LF: begin
        if (putc_en) begin
          putc_push = 1'b1;
          putc_char = CHAR_LF;
          last_tx_d = CHAR_LF;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= 8'h00;
      cnt_q       <= 2'd0;
      ch_q        <= 8'h00;
      val_q       <= 8'h00;
      val_valid_q <= 1'b0;
      err_q       <= 1'b0;
      last_tx_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      val_q       <= val_d;
      val_valid_q <= val_valid_d;
      err_q       <= err_d;
      last_tx_q   <= last_tx_d;
    end
  end

  // The pop is masked during reset so no character leaves the buffer unseen.
  assign getc_pop  = pop_c & ~rst;
  assign val       = val_q;
  assign val_valid = val_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_io_hex_reader.sv
// Self-checking bench for io_hex_reader: directed scenarios plus a random
// character stream, compared against a stream-level parsing model.
module tb_io_hex_reader;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       clk = 1'b0;
  logic       rst;
  logic       getc_en, putc_en, getc_pop, putc_push, val_valid, err;
  logic [7:0] getc_char, putc_char, val;
  logic       getc_en_b, putc_en_b, getc_pop_b, putc_push_b, val_valid_b, err_b;
  logic [7:0] getc_char_b, putc_char_b, val_b;

  io_hex_reader #(.ECHO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .getc_en(getc_en), .getc_char(getc_char), .getc_pop(getc_pop),
    .putc_en(putc_en), .putc_push(putc_push), .putc_char(putc_char),
    .val(val), .val_valid(val_valid), .err(err)
  );

  io_hex_reader #(.ECHO(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .getc_en(getc_en_b), .getc_char(getc_char_b), .getc_pop(getc_pop_b),
    .putc_en(putc_en_b), .putc_push(putc_push_b), .putc_char(putc_char_b),
    .val(val_b), .val_valid(val_valid_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_pop = -100;
  int pop_total = 0;
  int pe_mode = 0;
  bit pop_s = 1'b0, pop_s_b = 1'b0;

  logic [7:0] rxq[$], rxq_b[$];
  logic [7:0] act_tx[$], exp_tx[$], act_val[$], exp_val[$], val_b_log[$];
  logic [3:0] pend[$];
  int act_err = 0, exp_err = 0, err_b_cnt = 0, push_b_cnt = 0;
  int pop_cyc[$], pop_cyc_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: applies the parsing rules to the character stream as a whole.
  task automatic put_ch(input logic [7:0] c);
    logic       is_hex;
    logic [3:0] nib;
    rxq.push_back(c);
    exp_tx.push_back(c);
    if (c == CR) exp_tx.push_back(LF);
    is_hex = 1'b1;
    nib    = 4'd0;
    if (c >= "0" && c <= "9")      nib = 4'(c - "0");
    else if (c >= "a" && c <= "f") nib = 4'(c - "a" + 10);
    else if (c >= "A" && c <= "F") nib = 4'(c - "A" + 10);
    else is_hex = 1'b0;
    if (is_hex) begin
      if (pend.size() < 2) pend.push_back(nib);
      else begin exp_err++; pend.delete(); end
    end else if (c == CR || c == LF) begin
      if (pend.size() == 2) exp_val.push_back({pend[0], pend[1]});
      else if (pend.size() == 1) exp_err++;
      pend.delete();
    end else begin
      exp_err++;
      pend.delete();
    end
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) put_ch(s[i]);
  endtask

  task automatic note_pops();
    pop_s   = getc_pop;
    pop_s_b = getc_pop_b;
    if (getc_pop) begin
      pop_total++;
      pop_cyc.push_back(cyc);
      last_pop = cyc;
    end
    if (getc_pop_b) pop_cyc_b.push_back(cyc);
  endtask

  // One clock: retire the pop taken at the edge, drive new inputs, then sample.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s)   void'(rxq.pop_front());
    if (pop_s_b) void'(rxq_b.pop_front());
    getc_en     = (rxq.size() != 0);
    getc_char   = getc_en ? rxq[0] : 8'h00;
    getc_en_b   = (rxq_b.size() != 0);
    getc_char_b = getc_en_b ? rxq_b[0] : 8'h00;
    putc_en     = (pe_mode == 0) ? 1'b1 : (pe_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    #1;
    if (val_valid || err) check("latency", cyc - last_pop, 2);
    if (val_valid) check("vv_err_excl", err, 0);
    if (val_valid) act_val.push_back(val);
    if (err) act_err++;
    if (putc_push) act_tx.push_back(putc_char);
    if (val_valid_b) val_b_log.push_back(val_b);
    if (err_b) err_b_cnt++;
    if (putc_push_b) push_b_cnt++;
    note_pops();
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      cycle();
      if (rxq.size() == 0 && act_tx.size() >= exp_tx.size()) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_timeout"}, done, 1);
    repeat (4) cycle();
  endtask

  task automatic check_streams(input string tag);
    check({tag, "_nval"}, act_val.size(), exp_val.size());
    foreach (exp_val[i]) if (i < act_val.size()) check({tag, "_val"}, act_val[i], exp_val[i]);
    check({tag, "_ntx"}, act_tx.size(), exp_tx.size());
    foreach (exp_tx[i]) if (i < act_tx.size()) check({tag, "_tx"}, act_tx[i], exp_tx[i]);
    check({tag, "_err"}, act_err, exp_err);
    act_val.delete(); exp_val.delete(); act_tx.delete(); exp_tx.delete();
    act_err = 0; exp_err = 0;
    pop_cyc.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pop"}, getc_pop, 0);
    check({tag, "_push"}, putc_push, 0);
    check({tag, "_pchar"}, putc_char, 0);
    check({tag, "_val"}, val, 0);
    check({tag, "_vv"}, val_valid, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [7:0] alpha [0:19];
    int p0;
    alpha = '{"0", "1", "2", "5", "7", "9", "a", "c", "f", "A",
              "B", "E", CR, LF, CR, LF, "g", "x", " ", "Z"};
    rst = 1'b1; getc_en = 1'b0; getc_char = 8'h00; putc_en = 1'b0;
    getc_en_b = 1'b0; getc_char_b = 8'h00; putc_en_b = 1'b1;

    // Reset state, with characters already waiting in both buffers.
    feed("4F"); put_ch(CR);
    rxq_b = '{"5", "e", CR, "z", "z", LF};
    repeat (3) cycle();
    check_outputs_zero("reset");
    rst = 1'b0;
    #1;
    note_pops();

    // "4F" CR: one commit, echo 34 46 0D 0A, 3-cycle character spacing.
    drain("t1");
    check("t1_npop", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("t1_gap0", pop_cyc[1] - pop_cyc[0], 3);
      check("t1_gap1", pop_cyc[2] - pop_cyc[1], 3);
    end
    check_streams("t1");
    check("t1_val", val, 8'h4F);

    // "a5" CRLF: single commit; CR costs 4 cycles.
    feed("a5"); put_ch(CR); put_ch(LF);
    drain("t2");
    check("t2_npop", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      check("t2_gap0", pop_cyc[1] - pop_cyc[0], 3);
      check("t2_gap1", pop_cyc[2] - pop_cyc[1], 3);
      check("t2_gap_cr", pop_cyc[3] - pop_cyc[2], 4);
    end
    check_streams("t2");

    // "123" CR: third digit errors, CR commits nothing, val holds.
    feed("123"); put_ch(CR);
    drain("t3");
    check_streams("t3");
    check("t3_val_hold", val, 8'hA5);

    // Non-hex character and a lone digit before LF.
    feed("G"); put_ch(LF); feed("7"); put_ch(LF);
    drain("t4");
    check_streams("t4");
    check("t4_val_hold", val, 8'hA5);

    // Echo backpressure stalls the receive side after one pop.
    pe_mode = 2;
    feed("9C"); put_ch(CR);
    p0 = pop_total;
    repeat (50) cycle();
    check("bp_pops_hold", pop_total - p0, 1);
    check("bp_no_push", act_tx.size(), 0);
    pe_mode = 0;
    drain("bp");
    check("bp_pops_after", pop_total - p0, 3);
    check_streams("bp");

    // ECHO=0 instance: 2-cycle spacing, no echo, same parsing.
    check("b_push", push_b_cnt, 0);
    check("b_nval", val_b_log.size(), 1);
    if (val_b_log.size() == 1) check("b_val", val_b_log[0], 8'h5E);
    check("b_err", err_b_cnt, 2);
    check("b_npop", pop_cyc_b.size(), 6);
    for (int i = 1; i < pop_cyc_b.size(); i++) check("b_gap", pop_cyc_b[i] - pop_cyc_b[i-1], 2);

    // Random characters with random echo backpressure.
    pe_mode = 1;
    for (int i = 0; i < 150; i++) put_ch(alpha[$urandom_range(0, 19)]);
    drain("rnd");
    check_streams("rnd");
    pe_mode = 0;

    // Reset while an echo is pending, then a clean restart.
    pe_mode = 2;
    feed("4");
    repeat (4) cycle();
    check("t7_waiting", putc_push, 0);
    rst = 1'b1;
    #1;
    check_outputs_zero("t7_rst");
    pend.delete();
    act_val.delete(); exp_val.delete(); act_tx.delete(); exp_tx.delete();
    act_err = 0; exp_err = 0;
    pop_cyc.delete();
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    note_pops();
    pe_mode = 0;
    feed("1C"); put_ch(CR);
    drain("t7");
    check_streams("t7");
    check("t7_val", val, 8'h1C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
